// File: rtl/instr_fetch_pkg.sv
// Shared fetch/controller definitions: widths, fetch FSM encoding
// and the bit positions of the fetch-related OPs control bits.
package instr_fetch_pkg;

  localparam int IR_W = 16;
  localparam int PC_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    REQ  = S_REQ,
    WAIT = S_WAIT,
    HOLD = S_HOLD
  } fetch_state_e;

  localparam int OP_FETCH = 0;
  localparam int OP_JMP   = 1;
  localparam int OP_JMPZ  = 2;
  localparam int OP_HALT  = 3;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC select: unconditional jump, then taken conditional
// jump, then optional increment (wraps modulo 2^PC_W).
module pc_next #(
  parameter int PC_W = 8
) (
  input  logic            inc,
  input  logic            jmp,
  input  logic            jmpz,
  input  logic            z,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] npc
);

  localparam logic [PC_W-1:0] ONE = 1;

  always_comb begin
    npc = pc;
    unique case (1'b1)
      jmp:        npc = target;
      (jmpz & z): npc = target;
      inc:        npc = pc + ONE;
      default:    npc = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one synchronous memory
// read per request and holds the fetched word in IR.
module instr_fetch #(
  parameter int IR_W = instr_fetch_pkg::IR_W,
  parameter int PC_W = instr_fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            fetch,
  input  logic            jmp,
  input  logic            jmpz,
  input  logic            z,
  input  logic            halt,
  input  logic [PC_W-1:0] target,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [IR_W-1:0] IR,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc,
  output logic            busy
);

  import instr_fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            irv_q, irv_d;
  logic            en_q, en_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            busy_q, busy_d;

  logic            sel_inc;
  logic            sel_jmp;
  logic            sel_jz;
  logic [PC_W-1:0] npc;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .inc    (sel_inc),
    .jmp    (sel_jmp),
    .jmpz   (sel_jz),
    .z      (z),
    .pc     (pc_q),
    .target (target),
    .npc    (npc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    sel_inc = 1'b0;
    sel_jmp = 1'b0;
    sel_jz  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          addr_d  = RESET_PC;
          en_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        ir_d    = imem_rdata;
        irv_d   = 1'b1;
        sel_inc = 1'b1;
        pc_d    = npc;
        state_d = HOLD;
      end
      HOLD: begin
        if (halt) begin
          irv_d   = 1'b0;
          state_d = IDLE;
        end else if (fetch) begin
          irv_d   = 1'b0;
          sel_jmp = jmp;
          sel_jz  = jmpz;
          pc_d    = npc;
          addr_d  = npc;
          en_d    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  assign imem_en   = en_q;
  assign imem_addr = addr_q;
  assign IR        = ir_q;
  assign ir_valid  = irv_q;
  assign pc        = pc_q;
  assign busy      = busy_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetches instructions for the controller.
- Holds the PC, reads the synchronous instruction memory, and presents a stable IR word to the controller's IR input.
- Applies PC updates (sequential, jump, jump-on-z) that the controller requests through its OPs control bits.
- Sits between instruction memory and the controller. It produces the IR that the controller consumes.

Parameters:
- IR_W, 16, instruction word width; matches the controller IR input.
- PC_W, 8, PC and instruction-memory address width.
- RESET_PC, 0, first address fetched after start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching from RESET_PC; sampled in IDLE only.
- fetch  in  1  controller request for the next instruction (OPs bit); sampled in HOLD only.
- jmp  in  1  with fetch: next PC = target.
- jmpz  in  1  with fetch: next PC = target if z=1.
- z  in  1  ALU zero flag, the same signal the controller receives.
- halt  in  1  stop fetching; sampled in HOLD only.
- target  in  PC_W  jump destination.
- imem_en  out  1  memory read enable.
- imem_addr  out  PC_W  memory read address.
- imem_rdata  in  IR_W  read data, valid one cycle after imem_en.
- IR  out  IR_W  instruction register to the controller.
- ir_valid  out  1  IR holds a freshly fetched instruction.
- pc  out  PC_W  current PC, which points to the next instruction.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock domain, clk. rst_n is asynchronous and active-low; its assertion forces all state at once.
- Reset values:
  - state=IDLE
  - pc=0, IR=0, ir_valid=0, imem_en=0, imem_addr=0, busy=0
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - On start=1: pc<=RESET_PC, go to REQ.
  - All other inputs are ignored.
- REQ:
  - imem_en=1, imem_addr=pc, both for exactly one cycle.
  - Always go to WAIT.
- WAIT:
  - imem_en=0.
  - At the edge: IR<=imem_rdata, ir_valid<=1, pc<=pc+1 modulo 2^PC_W (2^PC_W-1 wraps to 0), go to HOLD.
- HOLD:
  - IR and ir_valid are held stable until a request arrives.
  - halt=1 takes priority: ir_valid<=0, go to IDLE; pc and IR are kept.
  - Otherwise fetch=1: ir_valid<=0, go to REQ. The next pc is:
    - target if jmp=1 (jmp has priority over jmpz);
    - target if jmpz=1 and z=1;
    - otherwise pc, which already holds the incremented value.
  - jmp, jmpz, z and target are sampled only in a cycle where fetch=1.
- Latency:
  - start or fetch sampled at edge k → imem_en high in cycle k..k+1.
  - IR and ir_valid update at edge k+2.
  - Back-to-back fetch gives one instruction per 3 cycles.
- Inputs outside their sampling state (start outside IDLE; fetch/halt outside HOLD) are ignored, with no queuing.
- Simultaneous start and fetch in IDLE: start wins, fetch is ignored.
- Reset mid-operation in any state returns to the reset values. An in-flight memory read is discarded.
- A jump to the current pc is legal and refetches the same address.

Decomposition:
- Shared package, also used by the controller:
  - IR_W and PC_W constants.
  - State encoding localparams IDLE=0, REQ=1, WAIT=2, HOLD=3.
  - OPs bit indices for fetch, jmp, jmpz, halt.
- Sub-module: pc_next. Combinational next-PC select (increment, jump, conditional jump, with priority) kept in its own module so it can be unit-tested. The FSM and registers stay in instr_fetch.

Test Plan:
- Reset then start, memory[0]=21, memory[1]=0 → imem_en pulses at addr 0; after 2 edges IR=21, ir_valid=1, pc=1. Then fetch → IR=0, pc=2.
- In HOLD with pc=5: fetch with jmp=1, target=40 → imem_addr=40, IR=memory[40], pc=41.
- fetch with jmpz=1, target=40: z=0 → fetched address 5; z=1 → fetched address 40. jmp=1 and jmpz=1 with z=0 → address 40.
- pc=255 with PC_W=8: sequential fetch at 255 → pc wraps to 0, next fetch reads address 0.
- halt in HOLD → ir_valid=0, busy=0, state IDLE. A fetch pulse while IDLE → no imem_en.
- rst_n low during WAIT → all outputs 0 immediately, without a clock edge. After release, start refetches RESET_PC.
